pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Parametrised pipeline hazard controller for the in-order CPU core; successor to the fixed two-source stall controller.
- Accepts one stall request per pipeline stage and produces the per-stage stall vector (bit 0 = PC, ascending toward write-back).
- Adds exception/branch-redirect flush sequencing with new-PC delivery, a saturating stall-cycle counter and a stall watchdog.
- Sits beside the pipeline registers; all pipeline registers consume stall, flush and new_pc.

Parameters:
- STAGES, 6, number of stall bits / pipeline stages (bit 0 = PC register). Legal range 2..16.
- AW, 32, width of the redirect PC.
- FLUSH_CYCLES, 1, cycles flush is held after a flush request. Legal range 1..7.
- CW, 16, width of the stall-cycle counter.
- TIMEOUT, 1023, consecutive stalled cycles at which stall_timeout sets. Legal range 1..2^CW-1.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high (`RstEnable`).
- stallreq  in  STAGES  bit i = stage i requests a stall this cycle.
- flush_req  in  1  single-cycle flush request from the exception/commit stage.
- flush_pc  in  AW  redirect target, sampled when flush_req=1.
- stall  out  STAGES  per-stage hold; combinational from stallreq and state.
- flush  out  1  pipeline-register clear; registered.
- new_pc  out  AW  redirect PC for the fetch stage; registered; valid while flush=1.
- stall_cnt  out  CW  total cycles with stall≠0 since reset; saturates.
- stall_timeout  out  1  sticky watchdog flag.
- busy  out  1  1 while in FLUSH state.

Behaviour:
- Reset: while rst=1 at a clock edge, state←RUN; flush←0; new_pc←0; stall_cnt←0; stall_timeout←0; run counter←0; flush counter←0. While rst=1, stall=0 combinationally.
- Stall vector: in RUN, let h = highest index with stallreq[h]=1. Set stall[k]=1 for all k≤h and 0 above. Stage h+1 takes a bubble (its own logic). If stallreq=0, stall=0.
- The stall vector is combinational, with zero latency from stallreq, so a same-cycle request freezes the same edge.
- Examples for STAGES=6: stallreq=000100→stall=000111; stallreq=001010→stall=001111.
- States:
  - RUN: normal operation.
  - FLUSH: flush sequence in progress; stall forced to all-zero; stallreq ignored.
- RUN→FLUSH: flush_req=1 at an edge. On that edge: flush←1; new_pc←flush_pc; flush counter←FLUSH_CYCLES-1; busy←1.
- flush_req has priority over stallreq in the same cycle. stall is still driven from stallreq in that request cycle.
- FLUSH: if the flush counter is 0 at an edge, then state←RUN, flush←0, busy←0, and new_pc is held. Otherwise the counter decrements. flush stays high for exactly FLUSH_CYCLES cycles.
- flush_req during FLUSH restarts the sequence: new_pc←new flush_pc and the counter reloads. flush stays continuously high.
- stall_cnt: increments on each edge where stall≠0. It holds at 2^CW-1 and never wraps.
- Watchdog:
  - A run counter (width CW) increments on each edge where stall≠0 and clears on any edge where stall=0.
  - When the run counter reaches TIMEOUT, stall_timeout←1 on that edge.
  - The flag stays set until rst. A flush does not clear it.
  - The run counter saturates like stall_cnt.
- Reset mid-flush: rst wins. flush drops on the next edge. No partial sequence resumes.
- No X propagation: an unknown stallreq bit at reset is irrelevant because stall is forced to 0.

Test Plan:
- Reset: assert rst 2 cycles with stallreq=111111 and flush_req=1 → stall=0, flush=0, new_pc=0, stall_cnt=0, stall_timeout=0, busy=0.
- Stall encoding (STAGES=6): drive stallreq = 000001, 000010, 000100, 010100, 100000, 000000 in successive cycles → stall = 000001, 000011, 000111, 011111, 111111, 000000 in the same cycles; stall_cnt=5 afterwards.
- Flush: FLUSH_CYCLES=3; pulse flush_req with flush_pc=0x0000_0040 while stallreq=000100.
  - Required: stall=000111 in the request cycle.
  - Then flush=1, busy=1, new_pc=0x40 for exactly 3 cycles, with stall=0 despite stallreq=000100.
  - Then back to RUN with stall=000111.
- Re-flush: second flush_req with flush_pc=0x80 during the 2nd flush cycle → flush stays high 3 more cycles from that edge; new_pc=0x80 on the following edge.
- Watchdog and saturation: CW=4, TIMEOUT=5.
  - Hold stallreq=000010 for 20 cycles → stall_timeout rises on the 5th stalled edge; stall_cnt sticks at 15.
  - Drop stallreq → stall_timeout stays 1 until rst.
- Reset mid-flush: rst during the 2nd cycle of a 3-cycle flush → next edge flush=0, busy=0, new_pc=0; stallreq=000001 then gives stall=000001 immediately.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall vector, flush/redirect
// sequencing, saturating stall counter and sticky stall watchdog.
// Ports: clk, rst (sync, active-high), stallreq, flush_req, flush_pc
//        -> stall, flush, new_pc, stall_cnt, stall_timeout, busy.
module pipe_ctrl #(
  parameter int STAGES       = 6,
  parameter int AW           = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int CW           = 16,
  parameter int TIMEOUT      = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq,
  input  logic              flush_req,
  input  logic [AW-1:0]     flush_pc,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [AW-1:0]     new_pc,
  output logic [CW-1:0]     stall_cnt,
  output logic              stall_timeout,
  output logic              busy
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [CW-1:0] CMAX    = '1;
  localparam logic [CW-1:0] TO      = CW'(TIMEOUT);
  localparam logic [2:0]    FRELOAD = 3'(FLUSH_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_fcnt;
  logic [2:0]          w_fcnt_nxt;
  logic                r_flush;
  logic                w_flush_nxt;
  logic [AW-1:0]       r_new_pc;
  logic [AW-1:0]       w_new_pc_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [CW-1:0]       r_run;
  logic [CW-1:0]       w_run_nxt;
  logic                r_to;
  logic [STAGES-1:0]   w_smear;
  logic [STAGES-1:0]   w_stall;
  logic                w_any;
  logic                w_acc;

  // A stalled stage must also freeze every stage upstream of it,
  // so smear the highest request down toward the PC.
  always_comb begin
    w_acc   = 1'b0;
    w_smear = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      w_acc      = w_acc | stallreq[i];
      w_smear[i] = w_acc;
    end
  end

  assign w_stall = (rst || r_state == FLUSH) ? '0 : w_smear;
  assign w_any   = |w_stall;

  always_comb begin
    w_state_nxt  = r_state;
    w_fcnt_nxt   = r_fcnt;
    w_flush_nxt  = r_flush;
    w_new_pc_nxt = r_new_pc;
    if (flush_req) begin
      w_state_nxt  = FLUSH;
      w_fcnt_nxt   = FRELOAD;
      w_flush_nxt  = 1'b1;
      w_new_pc_nxt = flush_pc;
    end else if (r_state == FLUSH) begin
      if (r_fcnt == 3'd0) begin
        w_state_nxt = RUN;
        w_flush_nxt = 1'b0;
      end else begin
        w_fcnt_nxt = r_fcnt - 3'd1;
      end
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_any && r_cnt != CMAX) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
    w_run_nxt = '0;
    if (w_any) begin
      w_run_nxt = (r_run != CMAX) ? r_run + 1'b1 : r_run;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RUN;
      r_fcnt   <= '0;
      r_flush  <= 1'b0;
      r_new_pc <= '0;
      r_cnt    <= '0;
      r_run    <= '0;
      r_to     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_fcnt   <= w_fcnt_nxt;
      r_flush  <= w_flush_nxt;
      r_new_pc <= w_new_pc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_run    <= w_run_nxt;
      // Sticky: only reset clears it.
      r_to     <= r_to | (w_run_nxt >= TO);
    end
  end

  assign stall         = w_stall;
  assign flush         = r_flush;
  assign new_pc        = r_new_pc;
  assign stall_cnt     = r_cnt;
  assign stall_timeout = r_to;
  assign busy          = (r_state == FLUSH);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random
// traffic checked against a cycle-count reference model.
module tb_pipe_ctrl;

  localparam int STAGES = 6;
  localparam int AW     = 32;
  localparam int FC     = 3;
  localparam int CW     = 4;
  localparam int TOUT   = 5;
  localparam int CMAX   = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [STAGES-1:0] stallreq;
  logic              flush_req;
  logic [AW-1:0]     flush_pc;
  logic [STAGES-1:0] stall;
  logic              flush;
  logic [AW-1:0]     new_pc;
  logic [CW-1:0]     stall_cnt;
  logic              stall_timeout;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: remaining flush cycles rather than an FSM.
  int          m_frem;
  logic [31:0] m_pc;
  int          m_cnt;
  int          m_run;
  bit          m_to;

  pipe_ctrl #(
    .STAGES(STAGES), .AW(AW), .FLUSH_CYCLES(FC),
    .CW(CW), .TIMEOUT(TOUT)
  ) dut (
    .clk(clk), .rst(rst), .stallreq(stallreq),
    .flush_req(flush_req), .flush_pc(flush_pc),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_cnt(stall_cnt), .stall_timeout(stall_timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] ref_stall(logic [5:0] rq, logic r);
    if (r || m_frem > 0) return 6'd0;
    for (int i = 5; i >= 0; i--)
      if (rq[i]) return 6'((1 << (i + 1)) - 1);
    return 6'd0;
  endfunction

  task automatic model_reset();
    m_frem = 0; m_pc = 0; m_cnt = 0; m_run = 0; m_to = 0;
  endtask

  task automatic cyc(input logic [5:0] rq, input logic fr,
                     input logic [31:0] pc, input logic r);
    logic [5:0] es;
    stallreq = rq; flush_req = fr; flush_pc = pc; rst = r;
    es = ref_stall(rq, r);
    @(negedge clk);
    chk("stall", 32'(stall), 32'(es));
    chk("flush", 32'(flush), 32'(m_frem > 0));
    chk("busy", 32'(busy), 32'(m_frem > 0));
    chk("new_pc", new_pc, m_pc);
    chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    chk("timeout", 32'(stall_timeout), 32'(m_to));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (es != 0) begin
        if (m_cnt < CMAX) m_cnt++;
        if (m_run < CMAX) m_run++;
      end else begin
        m_run = 0;
      end
      if (m_run >= TOUT) m_to = 1;
      if (fr) begin
        m_frem = FC;
        m_pc   = pc;
      end else if (m_frem > 0) begin
        m_frem--;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; stallreq = '1; flush_req = 1'b1; flush_pc = 32'hdead;
    model_reset();
    @(posedge clk); #1;
    // Reset with every request active.
    cyc(6'b111111, 1'b1, 32'h1234, 1'b1);
    cyc(6'b111111, 1'b1, 32'h1234, 1'b1);
    // Stall encoding.
    cyc(6'b000001, 1'b0, 0, 1'b0);
    cyc(6'b000010, 1'b0, 0, 1'b0);
    cyc(6'b000100, 1'b0, 0, 1'b0);
    cyc(6'b010100, 1'b0, 0, 1'b0);
    cyc(6'b100000, 1'b0, 0, 1'b0);
    cyc(6'b000000, 1'b0, 0, 1'b0);
    chk("cnt_after_enc", 32'(stall_cnt), 32'd5);
    // Flush with stall request in the same cycle.
    cyc(6'b000100, 1'b1, 32'h40, 1'b0);
    for (int i = 0; i < FC; i++) begin
      chk("flush_hold", 32'(flush), 32'd1);
      cyc(6'b000100, 1'b0, 0, 1'b0);
    end
    chk("flush_done", 32'(flush), 32'd0);
    cyc(6'b000100, 1'b0, 0, 1'b0);
    // Re-flush on the second flush cycle.
    cyc(6'b000000, 1'b1, 32'h40, 1'b0);
    cyc(6'b000000, 1'b0, 0, 1'b0);
    cyc(6'b000000, 1'b1, 32'h80, 1'b0);
    chk("reflush_pc", new_pc, 32'h80);
    for (int i = 0; i < FC + 1; i++) cyc(6'b000001, 1'b0, 0, 1'b0);
    // Watchdog and saturation.
    cyc(6'b000000, 1'b0, 0, 1'b1);
    for (int i = 0; i < 20; i++) cyc(6'b000010, 1'b0, 0, 1'b0);
    chk("cnt_sat", 32'(stall_cnt), 32'd15);
    for (int i = 0; i < 4; i++) cyc(6'b000000, 1'b0, 0, 1'b0);
    chk("to_sticky", 32'(stall_timeout), 32'd1);
    // Reset mid-flush.
    cyc(6'b000000, 1'b0, 0, 1'b1);
    cyc(6'b000000, 1'b1, 32'h100, 1'b0);
    cyc(6'b000000, 1'b0, 0, 1'b0);
    cyc(6'b000000, 1'b0, 0, 1'b1);
    chk("rst_mid_flush", 32'(flush), 32'd0);
    cyc(6'b000001, 1'b0, 0, 1'b0);
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [5:0]  rq;
      logic        fr;
      logic        r;
      logic [31:0] pc;
      rq = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
      fr = ($urandom_range(0, 7) == 0);
      r  = ($urandom_range(0, 59) == 0);
      pc = $urandom;
      cyc(rq, fr, pc, r);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
